// File: rtl/clk_div_prog_if.sv
// Control/status bundle for the programmable clock divider.
// master drives the run/load controls, slave is the divider itself.
interface clk_div_prog_if #(
    parameter int WIDTH = 28
);
    logic             i_en;
    logic             i_restart;
    logic             i_load;
    logic [WIDTH-1:0] i_div_in;
    logic [WIDTH-1:0] i_high_in;
    logic             o_out;
    logic             o_tick;
    logic             o_pending;
    logic             o_applied;

    modport master (
        output i_en, i_restart, i_load, i_div_in, i_high_in,
        input  o_out, o_tick, o_pending, o_applied
    );

    modport slave (
        input  i_en, i_restart, i_load, i_div_in, i_high_in,
        output o_out, o_tick, o_pending, o_applied
    );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider with duty control and a period-start tick.
// New divisor/high-time sit in a shadow and are only applied at a period boundary.
module clk_div_prog #(
    parameter int          WIDTH        = 28,
    parameter int unsigned DEFAULT_DIV  = 50000000,
    parameter int unsigned DEFAULT_HIGH = 25000000
) (
    input  logic           clk,
    input  logic           rst_n,
    clk_div_prog_if.slave  bus
);
    localparam logic [WIDTH-1:0] L_DEF_DIV  = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] L_DEF_HIGH = WIDTH'(DEFAULT_HIGH);
    localparam logic [WIDTH-1:0] L_ONE      = WIDTH'(1);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_act_div;
    logic [WIDTH-1:0] r_act_high;
    logic [WIDTH-1:0] r_sh_div;
    logic [WIDTH-1:0] r_sh_high;
    logic             r_pending;
    logic             r_applied;
    logic             r_out;
    logic             r_tick;

    logic [WIDTH-1:0] w_eff_div;
    logic [WIDTH-1:0] w_last;
    logic             w_boundary;
    logic             w_apply;

    // A programmed divisor of 0 behaves exactly like 1.
    assign w_eff_div  = (r_act_div == '0) ? L_ONE : r_act_div;
    assign w_last     = w_eff_div - L_ONE;
    assign w_boundary = bus.i_en && (r_cnt >= w_last);
    assign w_apply    = r_pending && (!bus.i_en || bus.i_restart || w_boundary);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_out      <= 1'b0;
            r_tick     <= 1'b0;
            r_act_div  <= L_DEF_DIV;
            r_act_high <= L_DEF_HIGH;
            r_sh_div   <= L_DEF_DIV;
            r_sh_high  <= L_DEF_HIGH;
            r_pending  <= 1'b0;
            r_applied  <= 1'b0;
        end else begin
            if (!bus.i_en || bus.i_restart) begin
                r_cnt  <= '0;
                r_out  <= 1'b0;
                r_tick <= 1'b0;
            end else begin
                r_cnt  <= w_boundary ? '0 : r_cnt + L_ONE;
                r_out  <= (r_cnt < r_act_high);
                r_tick <= (r_cnt == '0);
            end

            // The apply consumes the old shadow even when a load lands in the same cycle.
            r_applied <= w_apply;
            if (w_apply) begin
                r_act_div  <= r_sh_div;
                r_act_high <= r_sh_high;
            end

            if (bus.i_load) begin
                r_sh_div  <= bus.i_div_in;
                r_sh_high <= bus.i_high_in;
                r_pending <= 1'b1;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign bus.o_out     = r_out;
    assign bus.o_tick    = r_tick;
    assign bus.o_pending = r_pending;
    assign bus.o_applied = r_applied;
endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: fixed vector table, directed corner sequences and
// randomized traffic, all checked against a period-position reference model.
module tb_clk_div_prog;
    localparam int W = 12;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    clk_div_prog_if #(.WIDTH(W)) ifc ();

    clk_div_prog #(.WIDTH(W), .DEFAULT_DIV(4), .DEFAULT_HIGH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // Reference model: position within the current period plus active/shadow settings.
    int m_div, m_high, s_div, s_high, m_pos;
    bit m_pend, m_out, m_tick, m_app;

    task automatic model_reset();
        m_div = 4; m_high = 2; s_div = 4; s_high = 2; m_pos = 0;
        m_pend = 0; m_out = 0; m_tick = 0; m_app = 0;
    endtask

    task automatic model_clk();
        int d;
        bit evt;
        d = (m_div == 0) ? 1 : m_div;
        if (!ifc.i_en || ifc.i_restart) begin
            m_out = 0; m_tick = 0; evt = 1; m_pos = 0;
        end else begin
            m_out  = (m_pos < m_high);
            m_tick = (m_pos == 0);
            evt    = (m_pos == d - 1);
            m_pos  = (m_pos + 1) % d;
        end
        m_app = evt && m_pend;
        if (m_app) begin
            m_div = s_div; m_high = s_high;
        end
        if (ifc.i_load) begin
            s_div = int'(ifc.i_div_in); s_high = int'(ifc.i_high_in); m_pend = 1;
        end else if (m_app) begin
            m_pend = 0;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".out"},     int'(ifc.o_out),     int'(m_out));
        chk({tag, ".tick"},    int'(ifc.o_tick),    int'(m_tick));
        chk({tag, ".pending"}, int'(ifc.o_pending), int'(m_pend));
        chk({tag, ".applied"}, int'(ifc.o_applied), int'(m_app));
    endtask

    task automatic drive(input bit en, input bit rs, input bit ld, input int d, input int h);
        ifc.i_en      = en;
        ifc.i_restart = rs;
        ifc.i_load    = ld;
        ifc.i_div_in  = W'(d);
        ifc.i_high_in = W'(h);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_clk();
        #1;
        chk_model(tag);
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    typedef struct {
        bit en, rs, ld;
        int d, h;
        bit e_out, e_tick, e_pend, e_app;
    } vec_t;

    vec_t vt[12];
    int   cnt;
    int   guard;

    initial begin
        n_cmp = 0; n_fail = 0;
        model_reset();
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("rst.out", int'(ifc.o_out), 0);
        chk("rst.tick", int'(ifc.o_tick), 0);
        chk("rst.pending", int'(ifc.o_pending), 0);
        chk("rst.applied", int'(ifc.o_applied), 0);
        #12;
        rst_n = 1'b1;
        @(negedge clk);

        // Defaults 4/2, then a 6/3 load at counter=1 that applies on the 4-cycle boundary.
        vt[0]  = '{1,0,0,0,0, 1,1,0,0};
        vt[1]  = '{1,0,1,6,3, 1,0,1,0};
        vt[2]  = '{1,0,0,0,0, 0,0,1,0};
        vt[3]  = '{1,0,0,0,0, 0,0,0,1};
        vt[4]  = '{1,0,0,0,0, 1,1,0,0};
        vt[5]  = '{1,0,0,0,0, 1,0,0,0};
        vt[6]  = '{1,0,0,0,0, 1,0,0,0};
        vt[7]  = '{1,0,0,0,0, 0,0,0,0};
        vt[8]  = '{1,0,0,0,0, 0,0,0,0};
        vt[9]  = '{1,0,0,0,0, 0,0,0,0};
        vt[10] = '{1,0,0,0,0, 1,1,0,0};
        vt[11] = '{1,0,0,0,0, 1,0,0,0};
        for (int i = 0; i < 12; i++) begin
            drive(vt[i].en, vt[i].rs, vt[i].ld, vt[i].d, vt[i].h);
            step("vec_model");
            chk($sformatf("vec%0d.out", i),     int'(ifc.o_out),     int'(vt[i].e_out));
            chk($sformatf("vec%0d.tick", i),    int'(ifc.o_tick),    int'(vt[i].e_tick));
            chk($sformatf("vec%0d.pending", i), int'(ifc.o_pending), int'(vt[i].e_pend));
            chk($sformatf("vec%0d.applied", i), int'(ifc.o_applied), int'(vt[i].e_app));
        end
        drive(1, 0, 0, 0, 0);
        run("dflt66", 8);

        // Degenerate divisors: 1/1, 0/0, then high-time above the divisor.
        drive(1, 0, 1, 1, 1); step("d1");
        drive(1, 0, 0, 0, 0); run("d1", 10);
        chk("d1.tick_every", int'(ifc.o_tick), 1);
        chk("d1.out_every", int'(ifc.o_out), 1);
        drive(1, 0, 1, 0, 0); step("d0");
        drive(1, 0, 0, 0, 0); run("d0", 6);
        chk("d0.tick_every", int'(ifc.o_tick), 1);
        chk("d0.out_zero", int'(ifc.o_out), 0);
        drive(1, 0, 1, 5, 9); step("d5h9");
        drive(1, 0, 0, 0, 0); run("d5h9", 12);
        chk("d5h9.out_const", int'(ifc.o_out), 1);

        // Two loads in one period yield a single apply pulse.
        guard = 0;
        while (m_pos != 0 && guard < 20) begin step("align"); guard++; end
        chk("align.reached", int'(m_pos == 0), 1);
        cnt = 0;
        drive(1, 0, 1, 5, 1); step("dbl"); cnt += int'(ifc.o_applied);
        drive(1, 0, 0, 0, 0); step("dbl"); cnt += int'(ifc.o_applied);
        drive(1, 0, 1, 7, 2); step("dbl"); cnt += int'(ifc.o_applied);
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin step("dbl"); cnt += int'(ifc.o_applied); end
        chk("dbl.applied_count", cnt, 1);

        // Disable mid-period, load while disabled, re-enable.
        run("pre_dis", 3);
        drive(0, 0, 0, 0, 0); step("dis");
        chk("dis.out", int'(ifc.o_out), 0);
        chk("dis.tick", int'(ifc.o_tick), 0);
        drive(0, 0, 1, 3, 1); step("dis_load");
        drive(0, 0, 0, 0, 0); step("dis_apply");
        chk("dis.applied", int'(ifc.o_applied), 1);
        drive(1, 0, 0, 0, 0); step("reen");
        chk("reen.out", int'(ifc.o_out), 1);
        run("reen", 8);

        // Restart at counter=2.
        drive(1, 0, 1, 6, 4); step("rs_pre");
        drive(1, 0, 0, 0, 0);
        guard = 0;
        while (m_pos != 2 && guard < 20) begin step("rs_align"); guard++; end
        drive(1, 1, 0, 0, 0); step("rs");
        chk("rs.out", int'(ifc.o_out), 0);
        drive(1, 0, 0, 0, 0); step("rs_first");
        chk("rs.first_tick", int'(ifc.o_tick), 1);
        run("rs_run", 10);

        // Async reset mid-period with a pending load.
        drive(1, 0, 1, 9, 5); step("ar_load");
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("ar.out", int'(ifc.o_out), 0);
        chk("ar.tick", int'(ifc.o_tick), 0);
        chk("ar.pending", int'(ifc.o_pending), 0);
        chk("ar.applied", int'(ifc.o_applied), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin step("ar_run"); cnt += int'(ifc.o_tick); end
        chk("ar.default_period_ticks", cnt, 3);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 19) != 0), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 14) == 0),
                  int'($urandom_range(0, 9)), int'($urandom_range(0, 11)));
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
